// File: rtl/wbu.sv
// wbu: write-back unit sitting between EXU/LSU and the 64-bit, 32-entry GPR file.
// Retires one instruction at a time. Loads issue one aligned doubleword read, then the
// addressed byte/half/word is extracted and sign- or zero-extended. The result is written
// to the register file in a single WB cycle, together with a commit pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_*                retire handshake and payload from EXU (in_ready high only in IDLE)
//   mem_req_*           read request (address aligned down to 8 bytes)
//   mem_rsp_*           single-beat read response, honoured only in WAIT
//   we_o/waddr_o/wdata_o  register file write port, valid for the one WB cycle
//   commit_o/commit_pc_o  retire pulse and PC for trace logic
//   err_o               one-cycle pulse in WB for a misaligned or illegal load
module wbu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_pc,
   input  logic [4:0]  in_rd,
   input  logic        in_rd_we,
   input  logic        in_is_load,
   input  logic [2:0]  in_ld_funct3,
   input  logic [63:0] in_result,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [63:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_data,
   output logic        we_o,
   output logic [4:0]  waddr_o,
   output logic [63:0] wdata_o,
   output logic        commit_o,
   output logic [63:0] commit_pc_o,
   output logic        err_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [4:0]  rd_q, rd_d;
   logic        rd_we_q, rd_we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [63:0] result_q, result_d;
   logic        err_q, err_d;
   logic        we_q, we_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] commit_pc_q, commit_pc_d;

   logic        ld_bad;
   logic [63:0] shifted;
   logic [63:0] ld_data;

   // Illegal funct3 or an access that crosses its natural alignment.
   always_comb begin
      ld_bad = (in_ld_funct3 == 3'b111);
      unique case (in_ld_funct3[1:0])
         2'b01:   ld_bad = ld_bad | in_result[0];
         2'b10:   ld_bad = ld_bad | (|in_result[1:0]);
         2'b11:   ld_bad = ld_bad | (|in_result[2:0]);
         default: ;
      endcase
   end

   // Shift the addressed bytes down to bit 0, then extend by load type.
   always_comb begin
      shifted = mem_rsp_data >> {result_q[2:0], 3'b000};
      unique case (funct3_q)
         3'b000:  ld_data = {{56{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_data = {{48{shifted[15]}}, shifted[15:0]};
         3'b010:  ld_data = {{32{shifted[31]}}, shifted[31:0]};
         3'b100:  ld_data = {56'd0, shifted[7:0]};
         3'b101:  ld_data = {48'd0, shifted[15:0]};
         3'b110:  ld_data = {32'd0, shifted[31:0]};
         default: ld_data = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      rd_d        = rd_q;
      rd_we_d     = rd_we_q;
      funct3_d    = funct3_q;
      result_d    = result_q;
      err_d       = err_q;
      we_d        = we_q;
      req_addr_d  = req_addr_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      commit_pc_d = commit_pc_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               pc_d     = in_pc;
               rd_d     = in_rd;
               rd_we_d  = in_rd_we;
               funct3_d = in_ld_funct3;
               result_d = in_result;
               err_d    = in_is_load & ld_bad;
               if (in_is_load && !ld_bad) begin
                  state_d    = StReq;
                  req_addr_d = {in_result[63:3], 3'b000};
               end else begin
                  state_d = StWb;
               end
            end
         end
         StReq: begin
            // A response in this cycle is deliberately dropped.
            if (mem_req_ready) state_d = StWait;
         end
         StWait: begin
            if (mem_rsp_valid) begin
               result_d = ld_data;
               state_d  = StWb;
            end
         end
         StWb: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Write-port and trace registers only change on entry to WB so they hold otherwise.
      if (state_d == StWb) begin
         we_d        = rd_we_d && (rd_d != 5'd0) && !err_d;
         waddr_d     = rd_d;
         wdata_d     = result_d;
         commit_pc_d = pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         rd_q        <= '0;
         rd_we_q     <= 1'b0;
         funct3_q    <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         we_q        <= 1'b0;
         req_addr_q  <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         commit_pc_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rd_q        <= rd_d;
         rd_we_q     <= rd_we_d;
         funct3_q    <= funct3_d;
         result_q    <= result_d;
         err_q       <= err_d;
         we_q        <= we_d;
         req_addr_q  <= req_addr_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         commit_pc_q <= commit_pc_d;
      end
   end

   // Reset gates in_ready so EXU never handshakes while the unit is being cleared.
   assign in_ready      = (state_q == StIdle) && !rst;
   assign mem_req_valid = (state_q == StReq);
   assign mem_req_addr  = req_addr_q;
   assign commit_o      = (state_q == StWb);
   assign we_o          = (state_q == StWb) && we_q;
   assign err_o         = (state_q == StWb) && err_q;
   assign waddr_o       = waddr_q;
   assign wdata_o       = wdata_q;
   assign commit_pc_o   = commit_pc_q;

endmodule
